// File: rtl/weight2_row_buffer.sv
// weight2_row_buffer: double-buffered layer-2 weight row receiver; define W2_ROW_BUF_CHECK_EN for sticky wr_err protocol checking
module weight2_row_buffer #(
  parameter int DATA_W   = 16,
  parameter int NUM_OUT  = 10,
  parameter int ADDR_W   = 4,
  parameter int NUM_ROWS = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w2SramWeOffChip,
  input  logic [ADDR_W-1:0]         weight2AddrOffChip,
  input  logic [DATA_W-1:0]         weight2,
  input  logic                      row_take,
  output logic                      row_valid,
  output logic [NUM_OUT*DATA_W-1:0] row_data,
  output logic [7:0]                row_index,
  output logic                      last_row,
  output logic                      weight2_loadNextRow,
  output logic                      done,
  output logic                      wr_err
);
  logic [NUM_OUT*DATA_W-1:0] fill_bank;
  logic [NUM_OUT-1:0]        mask;
  logic [7:0]                fill_cnt;
  logic                      started, full, take, swap, addr_ok, wr_ok, more;
  // swap and write qualification, all from pre-edge state
  always_comb begin
    full     = &mask;
    take     = row_take && row_valid;
    swap     = full && (!row_valid || row_take);
    addr_ok  = 32'(weight2AddrOffChip) < NUM_OUT;
    wr_ok    = w2SramWeOffChip && addr_ok && !full && !done;
    more     = 32'(fill_cnt) + 1 < NUM_ROWS;
    last_row = row_valid && 32'(row_index) == NUM_ROWS - 1;
  end
  // FILL bank: capture host words and track which slots are written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_bank <= '0;
      mask      <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (wr_ok && 32'(weight2AddrOffChip) == k) begin
          fill_bank[k*DATA_W +: DATA_W] <= weight2;
          mask[k]                       <= 1'b1;
        end
      if (swap) mask <= '0;
    end
  end
  // READ bank, row sequencing and host requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_data            <= '0;
      row_valid           <= 1'b0;
      row_index           <= '0;
      fill_cnt            <= '0;
      started             <= 1'b0;
      weight2_loadNextRow <= 1'b0;
      done                <= 1'b0;
    end else begin
      started             <= 1'b1;
      weight2_loadNextRow <= !started || (swap && more && !done);
      if (swap) begin
        row_data  <= fill_bank;
        row_valid <= 1'b1;
        row_index <= fill_cnt;
        fill_cnt  <= fill_cnt + 8'd1;
      end else if (take) row_valid <= 1'b0;
      if (take && 32'(row_index) == NUM_ROWS - 1) done <= 1'b1;
    end
  end
`ifdef W2_ROW_BUF_CHECK_EN
  // sticky flag for dropped writes and takes with nothing presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_err <= 1'b0;
    else if ((w2SramWeOffChip && (!addr_ok || full || done)) || (row_take && !row_valid)) wr_err <= 1'b1;
  end
`else
  assign wr_err = 1'b0;
`endif
endmodule

// File: tb/tb_weight2_row_buffer.sv
// tb_weight2_row_buffer: directed self-checking bench for weight2_row_buffer
module tb_weight2_row_buffer;
  logic         clk = 1'b0, reset = 1'b0, we = 1'b0, row_take = 1'b0;
  logic [3:0]   addr = '0;
  logic [15:0]  wdata = '0;
  logic         row_valid, last_row, req, done, wr_err;
  logic [159:0] row_data, exp_row;
  logic [7:0]   row_index;
  int           passed = 0, total = 0;
  logic         err_exp;

  weight2_row_buffer dut (
    .clk(clk), .reset(reset), .w2SramWeOffChip(we), .weight2AddrOffChip(addr),
    .weight2(wdata), .row_take(row_take), .row_valid(row_valid), .row_data(row_data),
    .row_index(row_index), .last_row(last_row), .weight2_loadNextRow(req),
    .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [159:0] mkrow(input int base);
    logic [159:0] r;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'(base + k);
    return r;
  endfunction

  task automatic wr(input int a, input int d);
    we = 1'b1; addr = 4'(a); wdata = 16'(d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic fill_row(input int base);
    for (int k = 0; k < 10; k++) wr(k, base + k);
  endtask

  task automatic take();
    row_take = 1'b1;
    @(negedge clk);
    row_take = 1'b0;
  endtask

  initial begin
`ifdef W2_ROW_BUF_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", row_valid, 0);
    chk("rst_data", row_data, 0);
    chk("rst_index", row_index, 0);
    chk("rst_last", last_row, 0);
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", wr_err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("boot_req", req, 1);
    fill_row(16'h0100);
    chk("r0_pending_valid", row_valid, 0);
    chk("r0_pending_req", req, 0);
    @(negedge clk);
    chk("r0_valid", row_valid, 1);
    chk("r0_index", row_index, 0);
    chk("r0_data", row_data, mkrow(16'h0100));
    chk("r0_req", req, 1);
    @(negedge clk);
    chk("r0_req_once", req, 0);

    fill_row(16'h0200);
    @(negedge clk);
    chk("hold_valid", row_valid, 1);
    chk("hold_data", row_data, mkrow(16'h0100));
    chk("hold_req", req, 0);
    take();
    chk("r1_valid", row_valid, 1);
    chk("r1_index", row_index, 1);
    chk("r1_data", row_data, mkrow(16'h0200));
    chk("r1_req", req, 1);
    @(negedge clk);
    chk("r1_req_once", req, 0);

    take();
    chk("take_empty_valid", row_valid, 0);
    wr(3, 16'h1111);
    wr(3, 16'h2222);
    for (int k = 0; k < 9; k++) if (k != 3) wr(k, 16'h0300 + k);
    repeat (2) @(negedge clk);
    chk("partial_not_valid", row_valid, 0);
    wr(12, 16'hbeef);
    chk("addr12_err", wr_err, err_exp);
    wr(9, 16'h0309);
    @(negedge clk);
    exp_row = mkrow(16'h0300);
    exp_row[3*16 +: 16] = 16'h2222;
    chk("r2_valid", row_valid, 1);
    chk("r2_index", row_index, 2);
    chk("r2_data", row_data, exp_row);
    chk("r2_req", req, 1);

    fill_row(16'h0400);
    @(negedge clk);
    chk("both_full_req", req, 0);
    chk("both_full_index", row_index, 2);
    wr(0, 16'hdead);
    chk("overflow_data", row_data, exp_row);
    chk("overflow_err", wr_err, err_exp);
    take();
    chk("r3_valid", row_valid, 1);
    chk("r3_index", row_index, 3);
    chk("r3_data", row_data, mkrow(16'h0400));
    take();
    chk("r3_taken", row_valid, 0);

    for (int r = 4; r < 200; r++) begin
      fill_row(r * 256);
      @(negedge clk);
      chk("stream_index", row_index, 160'(r));
      chk("stream_data", row_data, mkrow(r * 256));
      chk("stream_last", last_row, 160'(r == 199));
      chk("stream_req", req, 160'(r < 199));
      chk("stream_done", done, 0);
      take();
      chk("stream_taken", row_valid, 0);
    end
    chk("final_done", done, 1);
    chk("final_last", last_row, 0);
    fill_row(16'h0900);
    repeat (2) @(negedge clk);
    chk("post_done_valid", row_valid, 0);
    chk("post_done_req", req, 0);
    chk("post_done_sticky", done, 1);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reboot_req", req, 1);
    chk("reboot_done", done, 0);
    for (int r = 0; r < 6; r++) begin
      fill_row(r * 16);
      @(negedge clk);
      take();
    end
    fill_row(16'h0600);
    @(negedge clk);
    chk("r6_index", row_index, 6);
    chk("r6_valid", row_valid, 1);
    for (int k = 0; k < 5; k++) wr(k, 16'h0700 + k);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", row_valid, 0);
    chk("async_data", row_data, 0);
    chk("async_index", row_index, 0);
    chk("async_last", last_row, 0);
    chk("async_req", req, 0);
    chk("async_err", wr_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rerel_req", req, 1);
    fill_row(16'h0a00);
    @(negedge clk);
    chk("rerel_valid", row_valid, 1);
    chk("rerel_index", row_index, 0);
    chk("rerel_data", row_data, mkrow(16'h0a00));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
